mem_stage: RTL and testbench

- MEM pipeline stage of the RV32I core, between ex_mem and mem_wb.
- Executes loads and stores over a req/gnt/rvalid data bus, aligns and extends load data, and generates store byte-enables.
- Non-memory instructions pass straight through to mem_wb.
- Requests a pipeline stall while a bus transaction is outstanding.

---
 rtl/mem_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: load/store bus sequencing, alignment and stall
//
// Purpose: executes loads and stores over a req/gnt/rvalid data bus, builds
// store byte-enables and lane-replicated store data, aligns and extends load
// data, and passes non-memory instructions straight through to mem_wb.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i, opcode_i,       instruction from ex_mem
//   funct3_i, mem_addr_i,
//   mem_wdata_i, reg_wdata_i,
//   reg_we_i, reg_waddr_i
//   dbus_req_o, dbus_we_o,   data bus request side
//   dbus_addr_o, dbus_be_o,
//   dbus_wdata_o, dbus_gnt_i
//   dbus_rvalid_i,           data bus response side
//   dbus_rdata_i
//   reg_wdata_o, reg_we_o,   writeback fields to mem_wb
//   reg_waddr_o, opcode_o
//   stall_o                  freeze IF..EX and hold ex_mem
//   misalign_o, bus_err_o    one-cycle exception pulses
module mem_stage #(
  parameter int         TIMEOUT  = 16,
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [6:0]  opcode_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          we_q, we_d;

  logic        is_load, is_store, is_mem, misaligned;
  logic [1:0]  off_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] load_data;

  assign is_load  = valid_i && (opcode_i == LOAD_OP);
  assign is_store = valid_i && (opcode_i == STORE_OP);
  assign is_mem   = is_load || is_store;
  assign off_in   = mem_addr_i[1:0];

  // funct3[1:0] encodes size for both signed and unsigned variants.
  assign misaligned = ((funct3_i[1:0] == 2'b01) && mem_addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (mem_addr_i[1:0] != 2'b00));

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = mem_wdata_i;
    if (is_store) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_in    = 4'b0001 << off_in;
          wdata_in = {4{mem_wdata_i[7:0]}};
        end
        2'b01: begin
          be_in    = 4'b0011 << off_in;
          wdata_in = {2{mem_wdata_i[15:0]}};
        end
        default: begin
          be_in    = 4'b1111;
          wdata_in = mem_wdata_i;
        end
      endcase
    end
  end

  // Load alignment works only from the latched address and funct3.
  assign shifted = dbus_rdata_i >> {addr_q[1:0], 3'b000};
  assign half    = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b101:  load_data = {16'h0, half};
      default: load_data = dbus_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = 32'h0;
    dbus_be_o    = 4'h0;
    dbus_wdata_o = 32'h0;
    reg_wdata_o  = reg_wdata_i;
    reg_we_o     = 1'b0;
    reg_waddr_o  = reg_waddr_i;
    opcode_o     = opcode_i;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = is_store;
            dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
            dbus_be_o    = be_in;
            dbus_wdata_o = wdata_in;
            stall_o      = 1'b1;
            addr_d       = mem_addr_i;
            be_d         = be_in;
            wdata_d      = wdata_in;
            funct3_d     = funct3_i;
            we_d         = is_store;
            cnt_d        = '0;
            state_d      = dbus_gnt_i ? S_WAIT : S_REQ;
          end
        end else if (valid_i) begin
          reg_we_o = reg_we_i;
        end
      end
      S_REQ: begin
        dbus_req_o   = 1'b1;
        dbus_we_o    = we_q;
        dbus_addr_o  = {addr_q[31:2], 2'b00};
        dbus_be_o    = be_q;
        dbus_wdata_o = wdata_q;
        stall_o      = 1'b1;
        if (dbus_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dbus_rvalid_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!we_q) begin
            reg_we_o    = reg_we_i;
            reg_wdata_o = load_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_err_o = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset forces every output low in the same cycle it is asserted.
    if (rst) begin
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = 32'h0;
      dbus_be_o    = 4'h0;
      dbus_wdata_o = 32'h0;
      reg_wdata_o  = 32'h0;
      reg_we_o     = 1'b0;
      reg_waddr_o  = 5'h0;
      opcode_o     = 7'h0;
      stall_o      = 1'b0;
      misalign_o   = 1'b0;
      bus_err_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'h0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] reg_wdata_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [6:0]  opcode_o;
  logic        stall_o;
  logic        misalign_o;
  logic        bus_err_o;

  int passed;
  int total;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_we_i     (reg_we_i),
    .reg_waddr_i  (reg_waddr_i),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_gnt_i   (dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i (dbus_rdata_i),
    .reg_wdata_o  (reg_wdata_o),
    .reg_we_o     (reg_we_o),
    .reg_waddr_o  (reg_waddr_o),
    .opcode_o     (opcode_o),
    .stall_o      (stall_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet();
    valid_i       = 1'b0;
    opcode_i      = 7'h0;
    funct3_i      = 3'h0;
    mem_addr_i    = 32'h0;
    mem_wdata_i   = 32'h0;
    reg_wdata_i   = 32'h0;
    reg_we_i      = 1'b0;
    reg_waddr_i   = 5'h0;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = 32'h0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    valid_i     = 1'b1;
    opcode_i    = op;
    funct3_i    = f3;
    mem_addr_i  = addr;
    mem_wdata_i = wd;
    reg_we_i    = 1'b1;
    reg_waddr_i = 5'd7;
    reg_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    issue(OP_LOAD, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({dbus_req_o, stall_o, reg_we_o, misalign_o, bus_err_o} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {dbus_req_o, stall_o, reg_we_o, misalign_o, bus_err_o});
    else passed++;
    total++;
    if (dbus_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", dbus_addr_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    quiet();
    #1;
    total++;
    if ({dbus_req_o, stall_o, reg_we_o} !== 3'b0) $display("FAIL reset_idle: got %b want 000", {dbus_req_o, stall_o, reg_we_o});
    else passed++;
  endtask

  task automatic test_alu();
    @(negedge clk);
    quiet();
    valid_i = 1'b1; opcode_i = OP_ALU; reg_wdata_i = 32'h1234;
    reg_waddr_i = 5'd5; reg_we_i = 1'b1;
    #1;
    total++;
    if (reg_wdata_o !== 32'h1234) $display("FAIL alu_wdata: got %h want 00001234", reg_wdata_o);
    else passed++;
    total++;
    if ({reg_waddr_o, reg_we_o, opcode_o} !== {5'd5, 1'b1, OP_ALU}) $display("FAIL alu_fields: got %h/%b/%h want 05/1/33", reg_waddr_o, reg_we_o, opcode_o);
    else passed++;
    total++;
    if ({stall_o, dbus_req_o} !== 2'b00) $display("FAIL alu_nobus: got %b want 00", {stall_o, dbus_req_o});
    else passed++;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    total++;
    if ({reg_we_o, dbus_req_o, stall_o} !== 3'b000) $display("FAIL novalid: got %b want 000", {reg_we_o, dbus_req_o, stall_o});
    else passed++;
  endtask

  task automatic test_lb();
    int stall_cnt;
    int req_cnt;
    stall_cnt = 0;
    req_cnt = 0;
    @(negedge clk);
    quiet();
    issue(OP_LOAD, 3'b000, 32'h103, 32'h0);
    dbus_gnt_i = 1'b1;
    #1;
    total++;
    if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) $display("FAIL lb_req: got %b %b %h %b want 1 0 00000100 1111", dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dbus_gnt_i = 1'b0;
        dbus_rvalid_i = (c == 3);
        dbus_rdata_i = (c == 3) ? 32'h80FF_0000 : 32'h0;
        #1;
      end
      stall_cnt += stall_o;
      req_cnt += dbus_req_o;
    end
    total++;
    if (reg_wdata_o !== 32'hFFFF_FF80 || reg_we_o !== 1'b1) $display("FAIL lb_data: got %h we %b want ffffff80 we 1", reg_wdata_o, reg_we_o);
    else passed++;
    total++;
    if (stall_cnt != 3 || req_cnt != 1) $display("FAIL lb_timing: got stall %0d req %0d want stall 3 req 1", stall_cnt, req_cnt);
    else passed++;
    @(negedge clk);
    quiet();
  endtask

  task automatic test_lhu();
    int bad;
    bad = 0;
    @(negedge clk);
    quiet();
    issue(OP_LOAD, 3'b101, 32'h202, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      dbus_gnt_i = (c == 3);
      #1;
      if (dbus_req_o !== 1'b1 || dbus_addr_o !== 32'h200 || stall_o !== 1'b1) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL lhu_hold: got %0d bad req cycles want 0", bad);
    else passed++;
    @(negedge clk);
    dbus_gnt_i = 1'b0;
    #1;
    total++;
    if ({dbus_req_o, stall_o} !== 2'b01) $display("FAIL lhu_wait: got %b want 01", {dbus_req_o, stall_o});
    else passed++;
    @(negedge clk);
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i = 32'hBEEF_1234;
    #1;
    total++;
    if (reg_wdata_o !== 32'h0000_BEEF || stall_o !== 1'b0) $display("FAIL lhu_data: got %h stall %b want 0000beef stall 0", reg_wdata_o, stall_o);
    else passed++;
    @(negedge clk);
    quiet();
  endtask

  task automatic test_sb();
    @(negedge clk);
    quiet();
    issue(OP_STORE, 3'b000, 32'h301, 32'hAABB_CCDD);
    dbus_gnt_i = 1'b1;
    #1;
    total++;
    if ({dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o} !== {1'b1, 1'b1, 4'b0010, 32'h300}) $display("FAIL sb_req: got %b %b %b %h want 1 1 0010 00000300", dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o);
    else passed++;
    total++;
    if (dbus_wdata_o !== 32'hDDDD_DDDD) $display("FAIL sb_wdata: got %h want dddddddd", dbus_wdata_o);
    else passed++;
    @(negedge clk);
    dbus_gnt_i = 1'b0;
    dbus_rvalid_i = 1'b1;
    #1;
    total++;
    if ({reg_we_o, stall_o} !== 2'b00) $display("FAIL sb_ack: got %b want 00", {reg_we_o, stall_o});
    else passed++;
    @(negedge clk);
    quiet();
    // SH at offset 2 exercises the halfword lane shift.
    issue(OP_STORE, 3'b001, 32'h302, 32'h1122_3344);
    dbus_gnt_i = 1'b1;
    #1;
    total++;
    if (dbus_be_o !== 4'b1100 || dbus_wdata_o !== 32'h3344_3344) $display("FAIL sh_lanes: got %b %h want 1100 33443344", dbus_be_o, dbus_wdata_o);
    else passed++;
    @(negedge clk);
    dbus_gnt_i = 1'b0;
    dbus_rvalid_i = 1'b1;
    @(negedge clk);
    quiet();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    quiet();
    issue(OP_LOAD, 3'b010, 32'h102, 32'h0);
    dbus_gnt_i = 1'b1;
    #1;
    total++;
    if ({misalign_o, dbus_req_o, reg_we_o, stall_o} !== 4'b1000) $display("FAIL lw_misalign: got %b want 1000", {misalign_o, dbus_req_o, reg_we_o, stall_o});
    else passed++;
    @(negedge clk);
    issue(OP_STORE, 3'b001, 32'h101, 32'h0);
    #1;
    total++;
    if ({misalign_o, dbus_req_o, reg_we_o, stall_o} !== 4'b1000) $display("FAIL sh_misalign: got %b want 1000", {misalign_o, dbus_req_o, reg_we_o, stall_o});
    else passed++;
    @(negedge clk);
    quiet();
    #1;
    total++;
    if ({misalign_o, dbus_req_o} !== 2'b00) $display("FAIL misalign_pulse: got %b want 00", {misalign_o, dbus_req_o});
    else passed++;
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    @(negedge clk);
    quiet();
    issue(OP_LOAD, 3'b010, 32'h400, 32'h0);
    dbus_gnt_i = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      #1;
      if (c < 16 && (bus_err_o !== 1'b0 || stall_o !== 1'b1)) bad++;
    end
    total++;
    if (bus_err_o !== 1'b1 || stall_o !== 1'b0 || reg_we_o !== 1'b0) $display("FAIL timeout_err: got err %b stall %b we %b want 1 0 0", bus_err_o, stall_o, reg_we_o);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL timeout_early: got %0d bad wait cycles want 0", bad);
    else passed++;
    @(negedge clk);
    quiet();
    #1;
    total++;
    if ({bus_err_o, stall_o, dbus_req_o} !== 3'b000) $display("FAIL timeout_idle: got %b want 000", {bus_err_o, stall_o, dbus_req_o});
    else passed++;
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    quiet();
    issue(OP_LOAD, 3'b010, 32'h500, 32'h0);
    @(negedge clk);
    #1;
    total++;
    if (dbus_req_o !== 1'b1 || dbus_addr_o !== 32'h500) $display("FAIL req_state: got %b %h want 1 00000500", dbus_req_o, dbus_addr_o);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (dbus_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", dbus_req_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    quiet();
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i = 32'hDEAD_BEEF;
    reg_we_i = 1'b1;
    #1;
    total++;
    if ({dbus_req_o, stall_o, reg_we_o} !== 3'b000) $display("FAIL late_rvalid: got %b want 000", {dbus_req_o, stall_o, reg_we_o});
    else passed++;
    @(negedge clk);
    quiet();
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1;
    quiet();
    test_reset();
    test_alu();
    test_lb();
    test_lhu();
    test_sb();
    test_misalign();
    test_timeout();
    test_reset_in_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
